// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and index-width helper for the multi-port register file
package regfile_pkg;

  localparam int DEF_SIZE        = 32;
  localparam int DEF_REG_NUM     = 8;
  localparam int DEF_READ_PORTS  = 2;
  localparam int DEF_WRITE_PORTS = 2;
  localparam int DEF_ZERO_REG    = 1;

  // A single-register file still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wsel.sv
// rtl/regfile_wsel.sv - combinational write-port priority resolver, highest-numbered port wins
module regfile_wsel
  import regfile_pkg::*;
#(
  parameter  int SIZE        = DEF_SIZE,
  parameter  int REG_NUM     = DEF_REG_NUM,
  parameter  int WRITE_PORTS = DEF_WRITE_PORTS,
  parameter  int ZERO_REG    = DEF_ZERO_REG,
  localparam int AW          = idx_width(REG_NUM)
) (
  input  logic [WRITE_PORTS-1:0]           reg_write,
  input  logic [WRITE_PORTS-1:0][AW-1:0]   write_reg,
  input  logic [WRITE_PORTS-1:0][SIZE-1:0] write_data,
  output logic [REG_NUM-1:0]               wr_en,
  output logic [REG_NUM-1:0][SIZE-1:0]     wr_data
);

  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    // Ascending scan so a later port overwrites an earlier one; indices >= REG_NUM never match.
    for (int r = 0; r < REG_NUM; r++) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (reg_write[p] && (write_reg[p] == AW'(r))) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = write_data[p];
        end
      end
    end
    if (ZERO_REG != 0) begin
      wr_en[0]   = 1'b0;
      wr_data[0] = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-to-read bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int SIZE        = DEF_SIZE,
  parameter  int REG_NUM     = DEF_REG_NUM,
  parameter  int READ_PORTS  = DEF_READ_PORTS,
  parameter  int WRITE_PORTS = DEF_WRITE_PORTS,
  parameter  int ZERO_REG    = DEF_ZERO_REG,
  localparam int AW          = idx_width(REG_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WRITE_PORTS-1:0]           reg_write,
  input  logic [WRITE_PORTS-1:0][AW-1:0]   write_reg,
  input  logic [WRITE_PORTS-1:0][SIZE-1:0] write_data,
  input  logic                             alloc_en,
  input  logic [AW-1:0]                    alloc_reg,
  input  logic [READ_PORTS-1:0][AW-1:0]    read_reg,
  output logic [READ_PORTS-1:0][SIZE-1:0]  read_data,
  output logic [READ_PORTS-1:0]            read_ready,
  output logic [REG_NUM-1:0]               busy
);

  logic [REG_NUM-1:0]                 wr_en;
  logic [REG_NUM-1:0][SIZE-1:0]       wr_data;

  logic [REG_NUM-1:0][SIZE-1:0]       regs_q, regs_d;
  logic [REG_NUM-1:0]                 busy_q, busy_d;
  logic [READ_PORTS-1:0][SIZE-1:0]    read_data_q, read_data_d;
  logic [READ_PORTS-1:0]              read_ready_q, read_ready_d;

  regfile_wsel #(
    .SIZE        (SIZE),
    .REG_NUM     (REG_NUM),
    .WRITE_PORTS (WRITE_PORTS),
    .ZERO_REG    (ZERO_REG)
  ) u_wsel (
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .wr_en      (wr_en),
    .wr_data    (wr_data)
  );

  // Next-state storage and scoreboard; alloc is applied after the write clear so it wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int r = 0; r < REG_NUM; r++) begin
      if (wr_en[r]) begin
        regs_d[r] = wr_data[r];
        busy_d[r] = 1'b0;
      end
      if (alloc_en && (alloc_reg == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  // Reads sample the post-edge state, which gives the same-cycle bypass for data and ready.
  always_comb begin
    read_data_d  = '0;
    read_ready_d = '1;
    for (int i = 0; i < READ_PORTS; i++) begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (read_reg[i] == AW'(r)) begin
          read_data_d[i]  = regs_d[r];
          read_ready_d[i] = ~busy_d[r];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q       <= '0;
      busy_q       <= '0;
      read_data_q  <= '0;
      read_ready_q <= '1;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      read_data_q  <= read_data_d;
      read_ready_q <= read_ready_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_ready = read_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp at default parameters
module tb_regfile_mp;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            reg_write;
  logic [1:0][2:0]       write_reg;
  logic [1:0][31:0]      write_data;
  logic                  alloc_en;
  logic [2:0]            alloc_reg;
  logic [1:0][2:0]       read_reg;
  logic [1:0][31:0]      read_data;
  logic [1:0]            read_ready;
  logic [7:0]            busy;

  int n_checks;
  int n_pass;

  regfile_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .alloc_en   (alloc_en),
    .alloc_reg  (alloc_reg),
    .read_reg   (read_reg),
    .read_data  (read_data),
    .read_ready (read_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write  = '0;
    write_reg  = '0;
    write_data = '0;
    alloc_en   = 1'b0;
    alloc_reg  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    idle();
    read_reg = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd0", read_data[0], 0);
    check("rst_rd1", read_data[1], 0);
    check("rst_rdy", read_ready, 2'b11);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // all indices read zero and ready after reset
    for (int k = 0; k < 4; k++) begin
      read_reg[0] = 3'(k);
      read_reg[1] = 3'(k + 4);
      tick();
      check("init_rd0", read_data[0], 0);
      check("init_rd1", read_data[1], 0);
      check("init_rdy", read_ready, 2'b11);
    end
    check("init_busy", busy, 0);

    // same-index write collision: port1 wins
    reg_write = 2'b11; write_reg[0] = 3'd3; write_reg[1] = 3'd3;
    write_data[0] = 32'h11; write_data[1] = 32'h22;
    tick(); idle();
    read_reg[0] = 3'd3; read_reg[1] = 3'd0;
    tick();
    check("prio_r3", read_data[0], 32'h22);

    // write/read bypass
    reg_write = 2'b01; write_reg[0] = 3'd5; write_data[0] = 32'hA5A5;
    read_reg[0] = 3'd5; read_reg[1] = 3'd3;
    tick(); idle();
    check("byp_rd0", read_data[0], 32'hA5A5);
    check("byp_rd1", read_data[1], 32'h22);
    check("byp_rdy", read_ready, 2'b11);

    // alloc then write releases the register
    alloc_en = 1'b1; alloc_reg = 3'd2;
    tick(); idle();
    check("alloc_busy", busy, 8'h04);
    read_reg[0] = 3'd2; read_reg[1] = 3'd5;
    tick();
    check("alloc_rdy", read_ready, 2'b10);
    reg_write = 2'b01; write_reg[0] = 3'd2; write_data[0] = 32'h7;
    tick(); idle();
    tick();
    check("wb_rd0", read_data[0], 32'h7);
    check("wb_rdy", read_ready, 2'b11);
    check("wb_busy", busy, 0);

    // ready follows the same-cycle alloc
    alloc_en = 1'b1; alloc_reg = 3'd1; read_reg[0] = 3'd1;
    tick(); idle();
    check("rdy_byp0", read_ready[0], 1'b0);
    check("rdy_busy", busy, 8'h02);
    reg_write = 2'b10; write_reg[1] = 3'd1; write_data[1] = 32'h33;
    tick(); idle();
    check("rdy_byp_rd", read_data[0], 32'h33);
    check("rdy_byp1", read_ready[0], 1'b1);
    check("rdy_clr", busy, 0);

    // alloc and write on the same index: busy stays set
    alloc_en = 1'b1; alloc_reg = 3'd4;
    reg_write = 2'b01; write_reg[0] = 3'd4; write_data[0] = 32'h44;
    read_reg[0] = 3'd4;
    tick(); idle();
    check("aw_busy", busy, 8'h10);
    check("aw_rd0", read_data[0], 32'h44);
    check("aw_rdy0", read_ready[0], 1'b0);

    // collision plus bypass on the read side
    reg_write = 2'b11; write_reg[0] = 3'd6; write_reg[1] = 3'd6;
    write_data[0] = 32'h1; write_data[1] = 32'h2;
    read_reg[0] = 3'd6; read_reg[1] = 3'd4;
    tick(); idle();
    check("pb_rd0", read_data[0], 32'h2);
    check("pb_rd1", read_data[1], 32'h44);
    check("pb_rdy", read_ready, 2'b01);

    // register 0 is hardwired
    reg_write = 2'b10; write_reg[1] = 3'd0; write_data[1] = 32'hFF;
    alloc_en = 1'b1; alloc_reg = 3'd0; read_reg[0] = 3'd0;
    tick(); idle();
    check("z_rd0", read_data[0], 0);
    check("z_rdy0", read_ready[0], 1'b1);
    check("z_busy", busy, 8'h10);

    // mid-operation reset
    reg_write = 2'b01; write_reg[0] = 3'd6; write_data[0] = 32'h9; read_reg[0] = 3'd6;
    tick(); idle();
    check("pre_rst_rd0", read_data[0], 32'h9);
    #3 rst_n = 1'b0;
    #1;
    check("arst_rd0", read_data[0], 0);
    check("arst_rd1", read_data[1], 0);
    check("arst_rdy", read_ready, 2'b11);
    check("arst_busy", busy, 0);
    reg_write = 2'b01; write_reg[0] = 3'd7; write_data[0] = 32'h77;
    alloc_en = 1'b1; alloc_reg = 3'd7;
    tick(); idle();
    rst_n = 1'b1;

    // first edge after release works normally
    reg_write = 2'b01; write_reg[0] = 3'd3; write_data[0] = 32'h55;
    read_reg[0] = 3'd6; read_reg[1] = 3'd3;
    tick(); idle();
    check("post_r6", read_data[0], 0);
    check("post_r3", read_data[1], 32'h55);
    check("post_rdy", read_ready, 2'b11);
    read_reg[0] = 3'd7; read_reg[1] = 3'd1;
    tick();
    check("post_r7", read_data[0], 0);
    check("post_r1", read_data[1], 0);
    check("post_rdy7", read_ready, 2'b11);
    check("post_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
